// File: rtl/bcd_feed_pkg.sv
// -----------------------------------------------------------------------------
// bcd_feed_pkg
// Shared constants and types for the binary-to-BCD display front end.
//   BLANK_NIBBLE   : nibble code the display driver renders as an unlit digit
//   ADJ3_THRESHOLD : double-dabble correction threshold (nibble >= 5 gets +3)
//   bcd_state_t    : conversion FSM state encoding
// -----------------------------------------------------------------------------
package bcd_feed_pkg;

    localparam logic [3:0] BLANK_NIBBLE   = 4'hF;
    localparam logic [3:0] ADJ3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ3_ADDEND    = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } bcd_state_t;

endpackage : bcd_feed_pkg

// File: rtl/bcd_feed_adj3.sv
// -----------------------------------------------------------------------------
// bcd_nibble_adj3
// Combinational double-dabble nibble corrector: values >= 5 get +3 so that
// the following left shift carries correctly into the next decimal digit.
// The add is 4 bits wide; no carry leaves the nibble.
// Ports:
//   i_nibble : BCD scratch nibble before correction
//   o_nibble : corrected nibble
// -----------------------------------------------------------------------------
module bcd_nibble_adj3
    import bcd_feed_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    assign o_nibble = (i_nibble >= ADJ3_THRESHOLD) ? (i_nibble + ADJ3_ADDEND)
                                                   : i_nibble;

endmodule : bcd_nibble_adj3

// File: rtl/bcd_feed.sv
// -----------------------------------------------------------------------------
// bcd_feed
// Sequential binary-to-BCD front end for the multiplexed seven-segment driver.
// A value is accepted over a valid/ready handshake, converted with one
// shift-add-3 step per input bit, optionally leading-zero blanked, and then
// written to the digit bus in a single commit cycle.
// Ports:
//   i_clk      : system clock (rising edge)
//   i_rst_n    : asynchronous active-low reset
//   i_valid    : requester presents a value on i_value
//   o_ready    : block is idle and will accept a value
//   i_value    : unsigned binary value to display
//   i_blank_lz : sampled with i_value; 1 = blank leading zeros
//   o_digits   : packed BCD, nibble 0 = least significant digit
//   o_busy     : conversion in progress (always ~o_ready)
//   o_overflow : last accepted value did not fit in DIGITS decimal digits
// -----------------------------------------------------------------------------
module bcd_feed
    import bcd_feed_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WIDTH-1:0]      i_value,
    input  logic                  i_blank_lz,
    output logic [DIGITS*4-1:0]   o_digits,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam int               BW       = DIGITS * 4;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);

    bcd_state_t          r_state;
    logic                r_ready;
    logic [WIDTH-1:0]    r_value;     // binary shift register
    logic [BW-1:0]       r_bcd;       // BCD scratch, never visible on o_digits
    logic                r_ovf;       // sticky: a 1 was shifted out of r_bcd
    logic                r_blank;     // leading-zero blanking requested
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_digits;
    logic                r_overflow;

    logic [BW-1:0]       w_adj;       // scratch after per-nibble +3 correction
    logic [BW-1:0]       w_blanked;   // scratch after leading-zero blanking

    // Per-nibble add-3 correction and leading-zero blanking.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
        bcd_nibble_adj3 u_adj3 (
            .i_nibble (r_bcd[gi*4 +: 4]),
            .o_nibble (w_adj[gi*4 +: 4])
        );

        if (gi == 0) begin : g_lsd
            // The least significant digit always shows, so 0 renders as "0".
            assign w_blanked[3:0] = r_bcd[3:0];
        end else if (gi == DIGITS - 1) begin : g_msd
            assign w_blanked[gi*4 +: 4] =
                (r_blank && (r_bcd[gi*4 +: 4] == 4'd0)) ? BLANK_NIBBLE
                                                         : r_bcd[gi*4 +: 4];
        end else begin : g_mid
            // Blank only when this nibble and everything above it are zero.
            logic w_upper_nz;
            assign w_upper_nz = |r_bcd[BW-1:(gi+1)*4];
            assign w_blanked[gi*4 +: 4] =
                (r_blank && !w_upper_nz && (r_bcd[gi*4 +: 4] == 4'd0))
                    ? BLANK_NIBBLE : r_bcd[gi*4 +: 4];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_value    <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_blank    <= 1'b0;
            r_cnt      <= '0;
            r_digits   <= {DIGITS{BLANK_NIBBLE}};
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_value <= i_value;
                        r_blank <= i_blank_lz;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        r_ready <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // {corrected scratch, value} << 1; the scratch MSB falls out
                    // and marks the value as too large for DIGITS digits.
                    r_bcd   <= {w_adj[BW-2:0], r_value[WIDTH-1]};
                    r_value <= {r_value[WIDTH-2:0], 1'b0};
                    r_ovf   <= r_ovf | w_adj[BW-1];
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    if (r_ovf) begin
                        r_digits   <= {DIGITS{BLANK_NIBBLE}};
                        r_overflow <= 1'b1;
                    end else begin
                        r_digits   <= w_blanked;
                        r_overflow <= 1'b0;
                    end
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_busy     = ~r_ready;
    assign o_digits   = r_digits;
    assign o_overflow = r_overflow;

endmodule : bcd_feed

// File: tb/tb_bcd_feed.sv
module tb_bcd_feed;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;

    logic                clk;
    logic                rst_n;
    logic                valid;
    logic                ready;
    logic [WIDTH-1:0]    value;
    logic                blank_lz;
    logic [DIGITS*4-1:0] digits;
    logic                busy;
    logic                overflow;

    int n_cmp;
    int n_bad;

    bcd_feed #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_value    (value),
        .i_blank_lz (blank_lz),
        .o_digits   (digits),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for o_ready, present a value, return 1 ns after the
    // handshake edge T with i_valid dropped and i_value/i_blank_lz scrambled.
    task automatic start_conv(input logic [WIDTH-1:0] v, input logic b);
        int k;
        k = 0;
        @(negedge clk);
        while (ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: o_ready=%b required 1", ready);
        end
        value    = v;
        blank_lz = b;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        value    = 14'h3FFF;
        blank_lz = ~b;
    endtask

    // Advance from 1 ns after edge T to 1 ns after edge T+n.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; value = '0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (digits !== 16'hFFFF) begin n_bad++; $display("FAIL reset_digits: got %h required FFFF", digits); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        $display("test_reset: digits=%h ready=%b busy=%b ovf=%b", digits, ready, busy, overflow);
    endtask

    task automatic test_convert_1234();
        start_conv(14'd1234, 1'b0);
        n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL 1234_busy_after_T: busy=%b ready=%b required 1/0", busy, ready); end
        for (int c = 1; c <= WIDTH; c++) begin
            step(1);
            n_cmp++;
            if (digits !== 16'hFFFF || ready !== 1'b0) begin
                n_bad++;
                $display("FAIL 1234_hold_T+%0d: digits=%h ready=%b required FFFF/0", c, digits, ready);
            end
        end
        step(1);
        n_cmp++; if (digits !== 16'h1234) begin n_bad++; $display("FAIL 1234_digits: got %h required 1234", digits); end
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL 1234_ready: ready=%b busy=%b required 1/0", ready, busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL 1234_ovf: got %b required 0", overflow); end
        $display("test_convert_1234: digits=%h ovf=%b", digits, overflow);
    endtask

    task automatic test_blanking();
        logic [WIDTH-1:0] vals [3];
        logic             blz  [3];
        logic [15:0]      exps [3];
        vals[0] = 14'd42; blz[0] = 1'b1; exps[0] = 16'hFF42;
        vals[1] = 14'd0;  blz[1] = 1'b1; exps[1] = 16'hFFF0;
        vals[2] = 14'd7;  blz[2] = 1'b0; exps[2] = 16'h0007;
        for (int i = 0; i < 3; i++) begin
            start_conv(vals[i], blz[i]);
            step(WIDTH + 1);
            n_cmp++;
            if (digits !== exps[i] || overflow !== 1'b0) begin
                n_bad++;
                $display("FAIL blank_%0d: digits=%h ovf=%b required %h/0", vals[i], digits, overflow, exps[i]);
            end
            $display("test_blanking: value=%0d blz=%b digits=%h", vals[i], blz[i], digits);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] vals [3];
        logic [15:0]      exps [3];
        logic             ovfs [3];
        vals[0] = 14'd9999;  exps[0] = 16'h9999; ovfs[0] = 1'b0;
        vals[1] = 14'd10000; exps[1] = 16'hFFFF; ovfs[1] = 1'b1;
        vals[2] = 14'd5;     exps[2] = 16'h0005; ovfs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_conv(vals[i], 1'b0);
            step(WIDTH + 1);
            n_cmp++;
            if (digits !== exps[i]) begin n_bad++; $display("FAIL ovf_digits_%0d: got %h required %h", vals[i], digits, exps[i]); end
            n_cmp++;
            if (overflow !== ovfs[i]) begin n_bad++; $display("FAIL ovf_flag_%0d: got %b required %b", vals[i], overflow, ovfs[i]); end
            $display("test_overflow: value=%0d digits=%h ovf=%b", vals[i], digits, overflow);
        end
    endtask

    task automatic test_busy_ignore();
        start_conv(14'd1234, 1'b0);
        step(2);
        // Single-cycle request while busy must be dropped, not queued.
        @(negedge clk);
        value = 14'd3; blank_lz = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        step(WIDTH + 1 - 3);
        n_cmp++; if (digits !== 16'h1234) begin n_bad++; $display("FAIL busy_ignore_digits: got %h required 1234", digits); end
        step(5);
        n_cmp++;
        if (ready !== 1'b1 || digits !== 16'h1234) begin
            n_bad++;
            $display("FAIL busy_ignore_not_queued: ready=%b digits=%h required 1/1234", ready, digits);
        end
        $display("test_busy_ignore: digits=%h ready=%b", digits, ready);
    endtask

    task automatic test_back_to_back();
        // Hold i_valid with 21; switch to 56 after the first handshake. The
        // second value goes in on the first edge where o_ready is high.
        start_conv(14'd21, 1'b0);
        value = 14'd56; blank_lz = 1'b1; valid = 1'b1;
        step(WIDTH);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first_busy: ready=%b required 0", ready); end
        step(1);
        n_cmp++; if (digits !== 16'h0021) begin n_bad++; $display("FAIL b2b_first_digits: got %h required 0021", digits); end
        step(1);
        valid = 1'b0; value = 14'd9;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: ready=%b required 0", ready); end
        step(WIDTH);
        n_cmp++; if (digits !== 16'h0021) begin n_bad++; $display("FAIL b2b_second_hold: got %h required 0021", digits); end
        step(1);
        n_cmp++; if (digits !== 16'hFF56 || ready !== 1'b1) begin n_bad++; $display("FAIL b2b_second_digits: got %h ready=%b required FF56/1", digits, ready); end
        $display("test_back_to_back: digits=%h", digits);
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_conv(14'd1234, 1'b0);
        step(WIDTH + 1);
        n_cmp++; if (digits !== 16'h1234) begin n_bad++; $display("FAIL rstmid_prev: got %h required 1234", digits); end
        start_conv(14'd8888, 1'b0);
        step(5);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (digits !== 16'hFFFF) begin n_bad++; $display("FAIL rstmid_digits: got %h required FFFF", digits); end
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: ready=%b busy=%b ovf=%b required 1/0/0", ready, busy, overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2 * WIDTH; c++) begin
            @(posedge clk); #1;
            if (digits === 16'h8888) seen = 1'b1;
        end
        n_cmp++; if (seen || digits !== 16'hFFFF) begin n_bad++; $display("FAIL rstmid_no_commit: digits=%h seen8888=%b required FFFF/0", digits, seen); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b required 1", ready); end
        $display("test_reset_mid: digits=%h ready=%b", digits, ready);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_convert_1234();
        test_blanking();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_bcd_feed
